// File: rtl/sram_word_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_word_ctrl_pkg : shared widths and FSM encoding for sram_word_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_word_ctrl_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;
  localparam int WORD_W      = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage : sram_word_ctrl_pkg

`default_nettype wire

// File: rtl/sram_word_ctrl.sv
// ----------------------------------------------------------------------------
// sram_word_ctrl : 32-bit load/store as two 16-bit SRAM cycles, freezing the pipeline
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic                   wr_en,
  output logic [WORD_W-1:0]      rd_data,
  output logic                   freeze,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [15:0]            waddr_q, waddr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic [SRAM_DATA_W-1:0] lo_q, lo_d;
  logic [WORD_W-1:0]      rd_data_q, rd_data_d;

  logic req;
  logic last;
  logic in_phase;
  logic drive_dq;
  logic unused_addr;

  assign req         = rd_en | wr_en;
  assign last        = (cnt_q == LAST_CNT);
  assign in_phase    = (state_q == LO) || (state_q == HI);
  assign drive_dq    = op_wr_q && in_phase;
  assign unused_addr = &{1'b0, addr[1:0]};

  // Low half is parked in lo_q so rd_data only ever changes when a whole word lands.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = 3'd0;
          op_wr_d = wr_en;
          waddr_d = addr[17:2];
          wdata_d = wr_data;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = 3'd0;
          if (!op_wr_q) lo_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (!op_wr_q) rd_data_d = {SRAM_DQ, lo_q};
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      op_wr_q   <= 1'b0;
      waddr_q   <= 16'd0;
      wdata_q   <= '0;
      lo_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      rd_data_q <= rd_data_d;
    end
  end

  // WE_N rises in the last cycle of a phase while address and data stay put.
  assign SRAM_WE_N = !(drive_dq && (cnt_q != LAST_CNT));
  assign SRAM_OE_N = !(!op_wr_q && in_phase);
  assign SRAM_DQ   = drive_dq ? ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0])
                              : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = {1'b0, waddr_q, (state_q == HI)};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign rd_data = rd_data_q;
  assign freeze  = !rst && req && (state_q != DONE);

endmodule : sram_word_ctrl

`default_nettype wire

// File: tb/tb_sram_word_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_word_ctrl : scoreboard bench for sram_word_ctrl (WAIT_CYCLES 1 and 3)
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_word_ctrl;

  localparam int W0 = 1;
  localparam int W1 = 3;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [17:0] sa;
    logic [15:0] dq;
    int          frz;
    int          oe;
    logic [31:0] rd;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [17:0] addr_a, addr_b, sa_a, sa_b;
  logic [31:0] wdata_a, wdata_b, rdd_a, rdd_b;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic        frz_a, frz_b, we_a, we_b, oe_a, oe_b;
  logic        ub_a, lb_a, ce_a, ub_b, lb_b, ce_b;
  wire  [15:0] dq_a, dq_b;

  sram_word_ctrl #(.WAIT_CYCLES(W0)) u_dut_a (
    .clk(clk), .rst(rst), .addr(addr_a), .wr_data(wdata_a), .rd_en(rd_a), .wr_en(wr_a),
    .rd_data(rdd_a), .freeze(frz_a), .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a), .SRAM_UB_N(ub_a),
    .SRAM_LB_N(lb_a), .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
  );

  sram_word_ctrl #(.WAIT_CYCLES(W1)) u_dut_b (
    .clk(clk), .rst(rst), .addr(addr_b), .wr_data(wdata_b), .rd_en(rd_b), .wr_en(wr_b),
    .rd_data(rdd_b), .freeze(frz_b), .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b), .SRAM_UB_N(ub_b),
    .SRAM_LB_N(lb_b), .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
  );

  // SRAM models; reset reloads the words used as preset read data
  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  assign dq_a = !oe_a ? mem_a[sa_a[5:0]] : 16'hzzzz;
  assign dq_b = !oe_b ? mem_b[sa_b[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      mem_a[10] <= 16'h5678;
      mem_a[11] <= 16'h1234;
      mem_b[16] <= 16'hCAFE;
      mem_b[17] <= 16'hF00D;
    end else begin
      if (!we_a) mem_a[sa_a[5:0]] <= dq_a;
      if (!we_b) mem_b[sa_b[5:0]] <= dq_b;
    end
  end

  item_t       q_a[$];
  item_t       q_b[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_mem [int];
  logic [31:0] last_rd [2];
  int          frz_c [2];
  int          oe_c [2];
  int          we_c [2];
  logic        prev_we [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void push(input int i, input item_t it);
    if (i == 0) q_a.push_back(it);
    else        q_b.push_back(it);
  endfunction

  function automatic bit pop(input int i, output item_t it);
    it = '{default: 0};
    if (i == 0) begin
      if (q_a.size() == 0) return 1'b0;
      it = q_a.pop_front();
    end else begin
      if (q_b.size() == 0) return 1'b0;
      it = q_b.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic mon(input int i, input int w, input logic we_n, input logic oe_n,
                     input logic frz, input logic req, input logic [17:0] sa,
                     input logic [15:0] dq, input logic [31:0] rd);
    item_t it;
    if (rst) begin
      frz_c[i] = 0; oe_c[i] = 0; we_c[i] = 0; prev_we[i] = 1'b1;
      return;
    end
    if (!we_n) begin
      if (prev_we[i]) begin
        if (!pop(i, it)) begin
          n_vec++; n_err++;
          $display("FAIL dut%0d unexpected_strobe: got addr 0x%05h, want none", i, sa);
        end else begin
          chk($sformatf("dut%0d strobe_kind", i), it.kind, K_WR);
          chk($sformatf("dut%0d strobe_addr", i), 32'(sa), 32'(it.sa));
          chk($sformatf("dut%0d strobe_dq", i), 32'(dq), 32'(it.dq));
        end
      end
      we_c[i]++;
    end else if (!prev_we[i]) begin
      chk($sformatf("dut%0d we_low_len", i), we_c[i], w);
      we_c[i] = 0;
    end
    prev_we[i] = we_n;
    if (!oe_n) oe_c[i]++;
    if (frz) begin
      frz_c[i]++;
    end else if (req) begin
      if (!pop(i, it)) begin
        n_vec++; n_err++;
        $display("FAIL dut%0d unexpected_done: got rd_data 0x%08h, want none", i, rd);
      end else begin
        chk($sformatf("dut%0d done_kind", i), it.kind, K_DONE);
        chk($sformatf("dut%0d freeze_len", i), frz_c[i], it.frz);
        chk($sformatf("dut%0d oe_low_len", i), oe_c[i], it.oe);
        chk($sformatf("dut%0d rd_data", i), rd, it.rd);
      end
      frz_c[i] = 0; oe_c[i] = 0;
    end else begin
      frz_c[i] = 0; oe_c[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, W0, we_a, oe_a, frz_a, rd_a | wr_a, sa_a, dq_a, rdd_a);
    mon(1, W1, we_b, oe_b, frz_b, rd_b | wr_b, sa_b, dq_b, rdd_b);
  end

  task automatic drive(input int i, input logic rd, input logic wr,
                       input logic [17:0] a, input logic [31:0] d);
    if (i == 0) begin rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d; end
    else        begin rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d; end
  endtask

  task automatic access(input int i, input logic rd, input logic wr,
                        input logic [17:0] a, input logic [31:0] d, input bit wait_done);
    item_t it;
    int    w;
    int    key;
    bit    done;
    w    = (i == 0) ? W0 : W1;
    key  = i * 65536 + int'(a[17:2]);
    done = 1'b0;
    @(posedge clk); #1;
    if (wr) begin
      it = '{kind: K_WR, sa: {1'b0, a[17:2], 1'b0}, dq: d[15:0], frz: 0, oe: 0, rd: 0};
      push(i, it);
      it.sa = {1'b0, a[17:2], 1'b1};
      it.dq = d[31:16];
      push(i, it);
      exp_mem[key] = d;
    end else begin
      last_rd[i] = exp_mem[key];
    end
    if (wait_done) begin
      it = '{kind: K_DONE, sa: 0, dq: 0, frz: 2 * w + 3, oe: wr ? 0 : 2 * w + 2, rd: last_rd[i]};
      push(i, it);
    end
    drive(i, rd, wr, a, d);
    if (wait_done) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (((i == 0) ? frz_a : frz_b) == 1'b0) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        n_vec++; n_err++;
        $display("FAIL dut%0d access_timeout: got freeze stuck high, want release", i);
      end
    end
  endtask

  task automatic go_idle(input int i);
    @(posedge clk); #1;
    drive(i, 1'b0, 1'b0, 18'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    exp_mem[5] = 32'h12345678;
    exp_mem[65536 + 8] = 32'hF00DCAFE;
    drive(0, 1'b1, 1'b0, 18'h00010, 32'd0);
    drive(1, 1'b0, 1'b0, 18'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_freeze", 32'(frz_a), 32'd0);
    chk("rst_we_n", 32'(we_a), 32'd1);
    chk("rst_oe_n", 32'(oe_a), 32'd1);
    chk("rst_sram_addr", 32'(sa_a), 32'd0);
    chk("rst_rd_data", rdd_a, 32'd0);
    chk("tie_offs", 32'({ub_a, lb_a, ce_a}), 32'd0);
    @(posedge clk); #1;
    rd_a = 1'b0;
    rst  = 1'b0;

    access(0, 1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, 1'b1);
    go_idle(0);
    access(0, 1'b1, 1'b0, 18'h00010, 32'd0, 1'b1);
    access(0, 1'b1, 1'b0, 18'h00014, 32'd0, 1'b1);
    go_idle(0);
    access(0, 1'b1, 1'b1, 18'h0001C, 32'h0000FFFF, 1'b1);
    go_idle(0);

    // reset lands in the second HI cycle of a store
    access(0, 1'b0, 1'b1, 18'h00018, 32'hA5A55A5A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst  = 1'b1;
    wr_a = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_n", 32'(we_a), 32'd1);
    chk("abort_oe_n", 32'(oe_a), 32'd1);
    chk("abort_freeze", 32'(frz_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 32'd0;
    @(negedge clk);
    chk("abort_rd_data", rdd_a, 32'd0);
    chk("abort_freeze_idle", 32'(frz_a), 32'd0);

    access(0, 1'b1, 1'b0, 18'h00018, 32'd0, 1'b1);
    access(0, 1'b1, 1'b0, 18'h0001C, 32'd0, 1'b1);
    go_idle(0);

    access(1, 1'b1, 1'b0, 18'h00020, 32'd0, 1'b1);
    go_idle(1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_a_drained", q_a.size(), 32'd0);
    chk("queue_b_drained", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sram_word_ctrl

`default_nettype wire
